// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync -- VGA raster timing generator (default 640x480@60, 25 MHz pixel)
//
// This module walks a pixel position (pix_x, pix_y) across an H_TOTAL x V_TOTAL
// raster. Each output is a register decoded from the position that was just
// loaded, so every output describes the same pixel in the same cycle.
//
// Ports
//   clock_25     in   1  pixel clock, all state on rising edge
//   reset_n      in   1  asynchronous active-low reset
//   pix_en       in   1  advance enable (tie high for one pixel per clock)
//   pix_x        out 10  horizontal position 0..H_TOTAL-1
//   pix_y        out 10  vertical position 0..V_TOTAL-1
//   video_on     out  1  position lies in the visible area
//   hsync        out  1  horizontal sync, active level = SYNC_POL
//   vsync        out  1  vertical sync, active level = SYNC_POL
//   line_start   out  1  one-clock strobe on entering pix_x==0
//   frame_start  out  1  one-clock strobe on entering (0,0)
// ---------------------------------------------------------------------------
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic       clock_25,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // The counters are 10 bits wide; a raster that does not fit is rejected
  // while elaborating rather than wrapping silently at run time.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_raster
    $error("vga_sync: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits so a full 1024-wide visible area still compares
  // correctly against a 10-bit position.
  localparam logic [10:0] H_VIS   = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS   = 11'(V_DISPLAY);
  localparam logic [10:0] HS_LO   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_HI   = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_LO   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_HI   = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ACT  = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = ~SYNC_ACT;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic in_window(input logic [9:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, pos} >= lo) && ({1'b0, pos} <= hi);
  endfunction

  function automatic logic below(input logic [9:0] pos, input logic [10:0] lim);
    return {1'b0, pos} < lim;
  endfunction

  function automatic logic sync_level(input logic active);
    return active ? SYNC_ACT : SYNC_IDLE;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       video_on_q, video_on_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Position one step ahead of the current one, used whenever pix_en is high.
  logic [9:0] x_adv;
  logic [9:0] y_adv;

  always_comb begin
    x_adv = x_q + 10'd1;
    y_adv = y_q;
    if (x_q == H_LAST) begin
      x_adv = '0;
      y_adv = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  // Next-state: the decode is taken from the position being loaded, so the
  // registered outputs never lag the registered position. When stalled the
  // decode of the held position reproduces the held levels, while the
  // strobes drop so each one lasts a single clock.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      x_d           = x_adv;
      y_d           = y_adv;
      line_start_d  = (x_adv == '0);
      frame_start_d = (x_adv == '0) && (y_adv == '0);
    end
    video_on_d = below(x_d, H_VIS) && below(y_d, V_VIS);
    hsync_d    = sync_level(in_window(x_d, HS_LO, HS_HI));
    // vsync depends on the line only, so it covers every pixel of its lines.
    vsync_d    = sync_level(in_window(y_d, VS_LO, VS_HI));
  end

  // Reset parks the raster on its last pixel so the first advance lands on
  // (0,0) with both strobes raised.
  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      video_on_q    <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
